key_pulse_conditioner: RTL and testbench
========================================

Name: key_pulse_conditioner

Overview:
- Conditions a raw, active-low, bouncing pushbutton into a clean, single-cycle enable pulse.
- Sits directly upstream of the 16-bit T-flip-flop counter, replacing the raw KEY as clock. Counter instead runs on the system clock, with this block's pulse gating its enable.
- Also supplies a debounced level, an optional hold-to-auto-repeat pulse train and an 8-bit press tally for the HEX display path.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a press or a release (20 ms at 50 MHz); must be ≥2.
- REPEAT_DELAY, 25000000, held cycles after the accepted press before the first auto-repeat pulse; must be ≥2.
- REPEAT_RATE, 5000000, cycles between successive auto-repeat pulses; must be ≥2.
- CNT_W, 25, width of the shared timing counter; must hold max(parameters)-1.

Ports:
- clock, input, 1, system clock; all state updates on its rising edge.
- clear, input, 1, asynchronous active-low reset.
- key_n, input, 1, raw pushbutton, 0 = pressed; asynchronous to clock, may bounce.
- repeat_en, input, 1, 1 = auto-repeat while held; synchronous, quasi-static.
- pulse, output, 1, one-clock-wide enable per accepted press or repeat.
- level, output, 1, debounced key state, 1 = pressed.
- press_count, output, 8, number of pulses issued, modulo 256.

Behaviour:
- Reset, clear=0, asynchronous: sync flops=1 (released), state=IDLE, counter=0, pulse=0, level=0, press_count=0. Takes effect immediately, mid-operation included. No pulse is emitted on or after deassertion unless a new press is fully qualified.
- Synchroniser: two flops on key_n; pressed_s = ~second flop. A key_n sampled low at edge 0 gives pressed_s=1 after edge 1.
- Counter: one CNT_W counter shared by all states. Cleared on every state change; otherwise increments.
- All outputs are registered.
- IDLE:
  - pressed_s=1 → CONFIRM_PRESS.
- CONFIRM_PRESS:
  - pressed_s=0 → IDLE, no pulse (bounce rejected).
  - counter==DEBOUNCE_CYCLES-1 with pressed_s=1 → HELD; pulse=1 and level=1 at that edge.
  - Latency: key_n held low from edge 0 gives pulse high for exactly the cycle after edge DEBOUNCE_CYCLES+2.
- HELD:
  - pressed_s=0 → CONFIRM_RELEASE.
  - repeat_en=1 and counter==REPEAT_DELAY-1 → REPEAT, with pulse.
- REPEAT:
  - pressed_s=0 → CONFIRM_RELEASE.
  - repeat_en=0 → HELD, no pulse.
  - counter==REPEAT_RATE-1 → stay in REPEAT, counter=0, pulse.
- CONFIRM_RELEASE:
  - pressed_s=1 → HELD, counter=0, no pulse (release bounce; level stays 1).
  - counter==DEBOUNCE_CYCLES-1 with pressed_s=0 → IDLE, level=0.
- Release conditions take priority over repeat timing when both occur on the same edge.
- pulse is never high on two consecutive cycles.
- press_count increments on every edge that sets pulse=1; 255 wraps to 0 with no flag.
- Release timing: key_n returns high and is sampled at edge r → level falls at edge r+DEBOUNCE_CYCLES+2.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Clean press: key_n low from edge 0 for 20 cycles, repeat_en=0 → single pulse after edge 6; level=1 from edge 6; press_count=1. Release sampled at edge 20 → level=0 at edge 26.
- Press bounce: key_n low 2 cycles, high 1, low 2, high → no pulse, level=0, press_count=0; state back in IDLE.
- Auto-repeat: repeat_en=1, key_n held low from edge 0 → pulses after edges 6, 16, 19, 22, 25… Clearing repeat_en at edge 23 → no further pulses while held.
- Release bounce: while HELD, key_n high for 2 cycles then low → level stays 1, no pulse, press_count unchanged.
- Reset mid-qualify: clear=0 at edge 3 of a press (state CONFIRM_PRESS) → all outputs 0 immediately. clear=1 while key_n is still low → pulse only after a full DEBOUNCE_CYCLES+2 from the first post-reset low sample.
- Wrap: 256 clean presses → press_count reads 255 then 0; exactly 256 pulses observed.

Source files
------------

// File: rtl/key_pulse_conditioner_if.sv
// rtl/key_pulse_conditioner_if.sv - key/repeat inputs and pulse/level/tally outputs of the key conditioner
interface key_pulse_conditioner_if;
   logic       key_n;
   logic       repeat_en;
   logic       pulse;
   logic       level;
   logic [7:0] press_count;

   modport master (
      output key_n,
      output repeat_en,
      input  pulse,
      input  level,
      input  press_count
   );

   modport slave (
      input  key_n,
      input  repeat_en,
      output pulse,
      output level,
      output press_count
   );
endinterface

// File: rtl/key_pulse_conditioner.sv
// rtl/key_pulse_conditioner.sv - debounced single-cycle press pulse, auto-repeat, level and press tally
module key_pulse_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_RATE     = 5000000,
   parameter int CNT_W           = 25
) (
   input logic                    clock,
   input logic                    clear,
   key_pulse_conditioner_if.slave bus
);

   localparam logic [2:0] S_IDLE            = 3'd0;
   localparam logic [2:0] S_CONFIRM_PRESS   = 3'd1;
   localparam logic [2:0] S_HELD            = 3'd2;
   localparam logic [2:0] S_REPEAT          = 3'd3;
   localparam logic [2:0] S_CONFIRM_RELEASE = 3'd4;

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);

   logic             sync1_q, sync2_q;
   logic             pressed_s;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;
   logic             level_q, level_d;
   logic [7:0]       press_count_q, press_count_d;

   // Both synchroniser flops reset to the released (high) state so reset never looks like a press.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= bus.key_n;
         sync2_q <= sync1_q;
      end
   end

   assign pressed_s = ~sync2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      pulse_d = 1'b0;
      level_d = level_q;

      case (state_q)
         S_IDLE: begin
            if (pressed_s) begin
               state_d = S_CONFIRM_PRESS;
            end
         end
         S_CONFIRM_PRESS: begin
            if (!pressed_s) begin
               state_d = S_IDLE;
            end else if (cnt_q == DB_LAST) begin
               state_d = S_HELD;
               pulse_d = 1'b1;
               level_d = 1'b1;
            end
         end
         S_HELD: begin
            if (!pressed_s) begin
               state_d = S_CONFIRM_RELEASE;
            end else if (bus.repeat_en && (cnt_q == RD_LAST)) begin
               state_d = S_REPEAT;
               pulse_d = 1'b1;
            end
         end
         // Release is tested first so it wins over a coincident repeat tick.
         S_REPEAT: begin
            if (!pressed_s) begin
               state_d = S_CONFIRM_RELEASE;
            end else if (!bus.repeat_en) begin
               state_d = S_HELD;
            end else if (cnt_q == RR_LAST) begin
               cnt_d   = '0;
               pulse_d = 1'b1;
            end
         end
         S_CONFIRM_RELEASE: begin
            if (pressed_s) begin
               state_d = S_HELD;
            end else if (cnt_q == DB_LAST) begin
               state_d = S_IDLE;
               level_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            level_d = 1'b0;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end

      press_count_d = press_count_q + {7'd0, pulse_d};
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         pulse_q       <= 1'b0;
         level_q       <= 1'b0;
         press_count_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pulse_q       <= pulse_d;
         level_q       <= level_d;
         press_count_q <= press_count_d;
      end
   end

   assign bus.pulse       = pulse_q;
   assign bus.level       = level_q;
   assign bus.press_count = press_count_q;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// tb/tb_key_pulse_conditioner.sv - self-checking bench for key_pulse_conditioner
module tb_key_pulse_conditioner;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RR = 3;

   logic       clock;
   logic       clear;
   int         total;
   int         bad;
   logic [7:0] exp_count;

   key_pulse_conditioner_if bus ();

   key_pulse_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY   (RD),
      .REPEAT_RATE    (RR),
      .CNT_W          (8)
   ) dut (
      .clock(clock),
      .clear(clear),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      bus.key_n = 1'b1;
      repeat (n) step();
   endtask

   task automatic do_reset();
      bus.key_n = 1'b1;
      clear = 1'b0;
      step();
      step();
      clear = 1'b1;
      exp_count = 8'd0;
   endtask

   task automatic test_reset();
      bus.key_n = 1'b1;
      bus.repeat_en = 1'b0;
      clear = 1'b0;
      #1;
      total++; if (bus.pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got %b want 0", bus.pulse); end
      total++; if (bus.level !== 1'b0) begin bad++; $display("FAIL reset_level got %b want 0", bus.level); end
      total++; if (bus.press_count !== 8'd0) begin bad++; $display("FAIL reset_count got %0d want 0", bus.press_count); end
      step();
      step();
      clear = 1'b1;
      exp_count = 8'd0;
      for (int k = 0; k < 10; k++) begin
         step();
         total++;
         if (bus.pulse !== 1'b0 || bus.level !== 1'b0 || bus.press_count !== 8'd0) begin
            bad++;
            $display("FAIL post_reset edge %0d got p=%b l=%b c=%0d want 0/0/0", k, bus.pulse, bus.level, bus.press_count);
         end
      end
   endtask

   task automatic test_clean_press();
      idle(10);
      bus.repeat_en = 1'b0;
      for (int k = 0; k < 30; k++) begin
         bus.key_n = (k < 20) ? 1'b0 : 1'b1;
         step();
         total++; if (bus.pulse !== (k == 6)) begin bad++; $display("FAIL clean_pulse edge %0d got %b want %b", k, bus.pulse, (k == 6)); end
         total++; if (bus.level !== (k >= 6 && k < 26)) begin bad++; $display("FAIL clean_level edge %0d got %b want %b", k, bus.level, (k >= 6 && k < 26)); end
      end
      exp_count = exp_count + 8'd1;
      total++; if (bus.press_count !== exp_count) begin bad++; $display("FAIL clean_count got %0d want %0d", bus.press_count, exp_count); end
   endtask

   task automatic test_press_bounce();
      idle(10);
      for (int k = 0; k < 20; k++) begin
         bus.key_n = (k == 0 || k == 1 || k == 3 || k == 4) ? 1'b0 : 1'b1;
         step();
         total++;
         if (bus.pulse !== 1'b0 || bus.level !== 1'b0) begin
            bad++;
            $display("FAIL bounce_out edge %0d got p=%b l=%b want 0/0", k, bus.pulse, bus.level);
         end
      end
      total++; if (bus.press_count !== exp_count) begin bad++; $display("FAIL bounce_count got %0d want %0d", bus.press_count, exp_count); end
      for (int k = 0; k < 10; k++) begin
         bus.key_n = 1'b0;
         step();
         total++; if (bus.pulse !== (k == 6)) begin bad++; $display("FAIL bounce_idle_pulse edge %0d got %b want %b", k, bus.pulse, (k == 6)); end
      end
      exp_count = exp_count + 8'd1;
      idle(12);
      total++; if (bus.press_count !== exp_count) begin bad++; $display("FAIL bounce_after_count got %0d want %0d", bus.press_count, exp_count); end
   endtask

   task automatic test_auto_repeat();
      idle(10);
      for (int k = 0; k < 40; k++) begin
         bus.key_n = 1'b0;
         bus.repeat_en = (k < 23) ? 1'b1 : 1'b0;
         step();
         total++;
         if (bus.pulse !== (k == 6 || k == 16 || k == 19 || k == 22)) begin
            bad++;
            $display("FAIL repeat_pulse edge %0d got %b want %b", k, bus.pulse, (k == 6 || k == 16 || k == 19 || k == 22));
         end
         total++; if (bus.level !== (k >= 6)) begin bad++; $display("FAIL repeat_level edge %0d got %b want %b", k, bus.level, (k >= 6)); end
      end
      bus.repeat_en = 1'b0;
      idle(12);
      exp_count = exp_count + 8'd4;
      total++; if (bus.press_count !== exp_count) begin bad++; $display("FAIL repeat_count got %0d want %0d", bus.press_count, exp_count); end
   endtask

   task automatic test_release_bounce();
      idle(10);
      bus.repeat_en = 1'b0;
      for (int k = 0; k < 30; k++) begin
         bus.key_n = (k == 10 || k == 11) ? 1'b1 : 1'b0;
         step();
         total++; if (bus.pulse !== (k == 6)) begin bad++; $display("FAIL relb_pulse edge %0d got %b want %b", k, bus.pulse, (k == 6)); end
         total++; if (bus.level !== (k >= 6)) begin bad++; $display("FAIL relb_level edge %0d got %b want %b", k, bus.level, (k >= 6)); end
      end
      exp_count = exp_count + 8'd1;
      total++; if (bus.press_count !== exp_count) begin bad++; $display("FAIL relb_count got %0d want %0d", bus.press_count, exp_count); end
      idle(12);
      total++; if (bus.level !== 1'b0) begin bad++; $display("FAIL relb_final_level got %b want 0", bus.level); end
   endtask

   task automatic test_reset_mid_qualify();
      idle(10);
      for (int k = 0; k < 3; k++) begin
         bus.key_n = 1'b0;
         step();
      end
      clear = 1'b0;
      #1;
      total++;
      if (bus.pulse !== 1'b0 || bus.level !== 1'b0 || bus.press_count !== 8'd0) begin
         bad++;
         $display("FAIL midreset_out got p=%b l=%b c=%0d want 0/0/0", bus.pulse, bus.level, bus.press_count);
      end
      step();
      step();
      clear = 1'b1;
      exp_count = 8'd0;
      for (int k = 0; k < 12; k++) begin
         step();
         total++; if (bus.pulse !== (k == 6)) begin bad++; $display("FAIL midreset_pulse edge %0d got %b want %b", k, bus.pulse, (k == 6)); end
         total++; if (bus.level !== (k >= 6)) begin bad++; $display("FAIL midreset_level edge %0d got %b want %b", k, bus.level, (k >= 6)); end
      end
      exp_count = 8'd1;
      idle(12);
      total++; if (bus.press_count !== exp_count) begin bad++; $display("FAIL midreset_count got %0d want %0d", bus.press_count, exp_count); end
   endtask

   task automatic test_wrap();
      int pulses;
      pulses = 0;
      bus.repeat_en = 1'b0;
      do_reset();
      idle(4);
      for (int i = 0; i < 256; i++) begin
         for (int k = 0; k < 17; k++) begin
            bus.key_n = (k < 8) ? 1'b0 : 1'b1;
            step();
            if (bus.pulse === 1'b1) pulses++;
         end
         if (i == 254) begin
            total++; if (bus.press_count !== 8'd255) begin bad++; $display("FAIL wrap_255 got %0d want 255", bus.press_count); end
         end
         if (i == 255) begin
            total++; if (bus.press_count !== 8'd0) begin bad++; $display("FAIL wrap_0 got %0d want 0", bus.press_count); end
         end
      end
      total++; if (pulses != 256) begin bad++; $display("FAIL wrap_pulses got %0d want 256", pulses); end
      exp_count = 8'd0;
   endtask

   task automatic test_random();
      bit         kq[$];
      bit         rq[$];
      bit         ep[$];
      bit         el[$];
      bit         lvl;
      bit         pprev;
      bit         p;
      bit         pl;
      bit         r;
      int         run;
      int         hs;
      logic [7:0] c;
      for (int e = 0; e < 40; e++) begin
         r = 1'($urandom_range(0, 1));
         for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
            repeat ($urandom_range(1, 3)) begin kq.push_back(1'b0); rq.push_back(r); end
            repeat ($urandom_range(1, 2)) begin kq.push_back(1'b1); rq.push_back(r); end
         end
         repeat ($urandom_range(6, 40)) begin kq.push_back(1'b0); rq.push_back(r); end
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) begin kq.push_back(1'b1); rq.push_back(r); end
            repeat ($urandom_range(4, 25)) begin kq.push_back(1'b0); rq.push_back(r); end
         end
         for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
            repeat ($urandom_range(1, 3)) begin kq.push_back(1'b1); rq.push_back(r); end
            repeat ($urandom_range(1, 2)) begin kq.push_back(1'b0); rq.push_back(r); end
         end
         repeat (14) begin kq.push_back(1'b1); rq.push_back(r); end
      end

      // Debounced level flips once the opposite value has been seen DB+1 samples in a row;
      // repeats fall at RD + n*RR after the most recent start of an unbroken hold.
      lvl = 1'b0; pprev = 1'b0; run = 0; hs = 0;
      for (int k = 0; k < kq.size(); k++) begin
         p  = (k >= 2) ? ~kq[k-2] : 1'b0;
         pl = 1'b0;
         if (p != lvl) run++; else run = 0;
         if (!lvl) begin
            if (run == DB + 1) begin lvl = 1'b1; pl = 1'b1; hs = k; run = 0; end
         end else begin
            if (p) begin
               if (!pprev) hs = k;
               else if (rq[k] && (k - hs) >= RD && ((k - hs - RD) % RR) == 0) pl = 1'b1;
            end
            if (run == DB + 1) begin lvl = 1'b0; run = 0; end
         end
         pprev = p;
         ep.push_back(pl);
         el.push_back(lvl);
      end

      do_reset();
      c = 8'd0;
      for (int k = 0; k < kq.size(); k++) begin
         bus.key_n = kq[k];
         bus.repeat_en = rq[k];
         step();
         if (ep[k]) c = c + 8'd1;
         total++; if (bus.pulse !== ep[k]) begin bad++; $display("FAIL rand_pulse step %0d got %b want %b", k, bus.pulse, ep[k]); end
         total++; if (bus.level !== el[k]) begin bad++; $display("FAIL rand_level step %0d got %b want %b", k, bus.level, el[k]); end
         total++; if (bus.press_count !== c) begin bad++; $display("FAIL rand_count step %0d got %0d want %0d", k, bus.press_count, c); end
      end
      bus.repeat_en = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      exp_count = 8'd0;
      clear = 1'b0;
      bus.key_n = 1'b1;
      bus.repeat_en = 1'b0;
      test_reset();
      test_clean_press();
      test_press_bounce();
      test_auto_repeat();
      test_release_bounce();
      test_reset_mid_qualify();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
